// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a single fixed-latency memory port.
// Optional MEM_ARB_RR_EN replaces fixed data priority with last-granted round-robin on ties.
module mem_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        mem_enable,
  output logic        mem_read_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  logic [2:0]  r_cnt;
  logic        r_sel_d;
  logic        r_if_gnt, r_if_valid, r_d_gnt, r_d_valid;
  logic [31:0] r_if_rdata, r_d_rdata;
  logic        r_mem_en, r_mem_rw;
  logic [31:0] r_mem_addr, r_mem_wdata;

  logic w_any;
  logic w_pick_d;
  logic w_sample;

  assign w_any    = if_req | d_req;
  assign w_sample = (r_state != StBusy);

`ifdef MEM_ARB_RR_EN
  // Cleared on reset so the first tie after reset goes to data.
  logic r_last_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_d <= 1'b0;
    end else if (w_sample && w_any) begin
      r_last_d <= w_pick_d;
    end
  end

  assign w_pick_d = d_req & ~(if_req & r_last_d);
`else
  assign w_pick_d = d_req;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cnt       <= 3'd0;
      r_sel_d     <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_if_valid  <= 1'b0;
      r_d_gnt     <= 1'b0;
      r_d_valid   <= 1'b0;
      r_if_rdata  <= 32'd0;
      r_d_rdata   <= 32'd0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_if_gnt   <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          if (w_any) begin
            r_state     <= StBusy;
            r_cnt       <= 3'(LATENCY);
            r_sel_d     <= w_pick_d;
            r_d_gnt     <= w_pick_d;
            r_if_gnt    <= ~w_pick_d;
            r_mem_en    <= 1'b1;
            r_mem_rw    <= w_pick_d & d_we;
            r_mem_addr  <= w_pick_d ? d_addr : if_addr;
            r_mem_wdata <= w_pick_d ? d_wdata : 32'd0;
          end else begin
            r_state <= StIdle;
          end
        end
        StBusy: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_state     <= StDone;
            r_mem_en    <= 1'b0;
            r_mem_rw    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            if (r_sel_d) begin
              r_d_valid <= 1'b1;
              r_d_rdata <= r_mem_rw ? 32'd0 : mem_data_out;
            end else begin
              r_if_valid <= 1'b1;
              r_if_rdata <= mem_data_out;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign if_gnt         = r_if_gnt;
  assign if_valid       = r_if_valid;
  assign if_rdata       = r_if_rdata;
  assign d_gnt          = r_d_gnt;
  assign d_valid        = r_d_valid;
  assign d_rdata        = r_d_rdata;
  assign mem_enable     = r_mem_en;
  assign mem_read_write = r_mem_rw;
  assign mem_address    = r_mem_addr;
  assign mem_data_in    = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level reference model.
// Honours MEM_ARB_RR_EN to select the expected tie-break rule.
module tb_mem_arbiter;
  localparam int unsigned L = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_data_out = '0;
  logic        if_gnt, if_valid, d_gnt, d_valid, mem_enable, mem_read_write;
  logic [31:0] if_rdata, d_rdata, mem_address, mem_data_in;

  mem_arbiter #(.LATENCY(L)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_enable(mem_enable), .mem_read_write(mem_read_write),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: one transaction at a time, occupying L memory cycles then one done cycle.
  int          busy_left;
  bit          m_sel_d, m_we, m_last_d;
  logic [31:0] m_addr, m_wdata;
  logic        e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_en, e_rw;
  logic [31:0] e_if_rdata, e_d_rdata, e_addr, e_wdata;

  int  p_i, p_d, p_wd;
  byte glog[$];

  task automatic model_reset();
    busy_left = 0; m_sel_d = 0; m_we = 0; m_last_d = 0; m_addr = '0; m_wdata = '0;
    e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0; e_en = 0; e_rw = 0;
    e_if_rdata = '0; e_d_rdata = '0; e_addr = '0; e_wdata = '0;
  endtask

  task automatic model_edge();
    bit pick_d;
    e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) begin
        if (m_sel_d) begin
          e_d_valid = 1;
          e_d_rdata = m_we ? 32'd0 : mem_data_out;
        end else begin
          e_if_valid = 1;
          e_if_rdata = mem_data_out;
        end
      end
    end else if (d_req || if_req) begin
      if (d_req && if_req) begin
`ifdef MEM_ARB_RR_EN
        pick_d = !m_last_d;
`else
        pick_d = 1;
`endif
      end else begin
        pick_d = d_req;
      end
      m_last_d  = pick_d;
      m_sel_d   = pick_d;
      busy_left = L;
      m_addr    = pick_d ? d_addr : if_addr;
      m_we      = pick_d && d_we;
      m_wdata   = pick_d ? d_wdata : 32'd0;
      if (pick_d) e_d_gnt = 1; else e_if_gnt = 1;
    end
    e_en    = (busy_left > 0);
    e_rw    = e_en && m_we;
    e_addr  = e_en ? m_addr : 32'd0;
    e_wdata = e_en ? m_wdata : 32'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_all();
    chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
    chk("d_gnt", 32'(d_gnt), 32'(e_d_gnt));
    chk("if_valid", 32'(if_valid), 32'(e_if_valid));
    chk("d_valid", 32'(d_valid), 32'(e_d_valid));
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata", d_rdata, e_d_rdata);
    chk("mem_enable", 32'(mem_enable), 32'(e_en));
    chk("mem_read_write", 32'(mem_read_write), 32'(e_rw));
    chk("mem_address", mem_address, e_addr);
    chk("mem_data_in", mem_data_in, e_wdata);
  endtask

  // Requesters follow the protocol: hold until granted, drop right after, maybe withdraw early.
  task automatic drive();
    mem_data_out = $urandom;
    if (if_req && e_if_gnt) begin
      if_req = 0; if_addr = $urandom;
    end else if (if_req && $urandom_range(0, 99) < p_wd) begin
      if_req = 0;
    end else if (!if_req && $urandom_range(0, 99) < p_i) begin
      if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (d_req && e_d_gnt) begin
      d_req = 0; d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
    end else if (d_req && $urandom_range(0, 99) < p_wd) begin
      d_req = 0;
    end else if (!d_req && $urandom_range(0, 99) < p_d) begin
      d_req = 1; d_we = $urandom_range(0, 1); d_addr = $urandom; d_wdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clock);
    cyc++;
    if (!reset) model_edge();
    @(negedge clock);
    check_all();
    if (d_gnt) glog.push_back("D");
    if (if_gnt) glog.push_back("I");
    drive();
  endtask

  initial begin
    logic [31:0] got_order, exp_order;
    bit found;
    model_reset();
    p_i = 0; p_d = 0; p_wd = 0;

    // Asynchronous reset forces outputs low without waiting for an edge.
    #2 reset = 1;
    #1 check_all();
    @(posedge clock);
    @(negedge clock);
    check_all();
    reset = 0;

    // Both requesters always requesting, starting from post-reset state.
    p_i = 100; p_d = 100;
    glog.delete();
    for (int i = 0; i < 40; i++) step();
    got_order = {8'(glog.size() > 0 ? glog[0] : "-"), 8'(glog.size() > 1 ? glog[1] : "-"),
                 8'(glog.size() > 2 ? glog[2] : "-"), 8'(glog.size() > 3 ? glog[3] : "-")};
`ifdef MEM_ARB_RR_EN
    exp_order = "DIDI";
`else
    exp_order = "DDDD";
`endif
    chk("tie_grant_order", got_order, exp_order);

    // Sparse traffic with early withdrawals, then dense traffic.
    p_i = 20; p_d = 20; p_wd = 15;
    for (int i = 0; i < 800; i++) step();
    p_i = 70; p_d = 70; p_wd = 5;
    for (int i = 0; i < 800; i++) step();

    // Reset in the second memory cycle of a transaction aborts it silently.
    p_i = 30; p_d = 30; p_wd = 0;
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      if (e_en && busy_left == L - 1) found = 1;
    end
    chk("rst_window_found", 32'(found), 32'd1);
    reset = 1;
    if_req = 0; d_req = 0;
    model_reset();
    #1 check_all();
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_all();
    reset = 0;

    p_i = 40; p_d = 40; p_wd = 10;
    for (int i = 0; i < 600; i++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
